// File: rtl/aclk_pkg.sv
// Shared constants and types for the APU/CPU phase generator.
package aclk_pkg;

   localparam int unsigned NTSC_CLK_DIV  = 12;
   localparam int unsigned NTSC_PHI2_LEN = 5;
   localparam int unsigned PAL_CLK_DIV   = 16;
   localparam int unsigned PAL_PHI2_LEN  = 6;
   localparam int unsigned APU_ACLK_DIV  = 2;

   typedef struct packed {
      logic phi1;
      logic phi2;
      logic aclk1;
      logic n_aclk2;
   } phase_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/aclk_phase_gen_if.sv
// Mode/reset inputs and phase outputs of aclk_phase_gen.
// HALT exists only when ACLK_PHASE_GEN_HALT_EN is defined.
interface aclk_phase_gen_if;

   logic PAL;
   logic RES;
`ifdef ACLK_PHASE_GEN_HALT_EN
   logic HALT;
`endif
   logic PHI1;
   logic PHI2;
   logic ACLK1;
   logic nACLK2;
   logic CYC_START;
   logic ACLK_START;

`ifdef ACLK_PHASE_GEN_HALT_EN
   modport master (input PAL, RES, HALT,
                   output PHI1, PHI2, ACLK1, nACLK2, CYC_START, ACLK_START);
   modport slave  (output PAL, RES, HALT,
                   input PHI1, PHI2, ACLK1, nACLK2, CYC_START, ACLK_START);
`else
   modport master (input PAL, RES,
                   output PHI1, PHI2, ACLK1, nACLK2, CYC_START, ACLK_START);
   modport slave  (output PAL, RES,
                   input PHI1, PHI2, ACLK1, nACLK2, CYC_START, ACLK_START);
`endif

endinterface

// File: rtl/cpu_cycle_divider.sv
// Master-clock to CPU-cycle divider: owns div_cnt and the latched NTSC/PAL mode.
// Emits phase-1 decode, wrap pulse and first-clock flag.
module cpu_cycle_divider
   import aclk_pkg::*;
#(
   parameter int unsigned CLK_DIV      = NTSC_CLK_DIV,
   parameter int unsigned PHI2_LEN     = NTSC_PHI2_LEN,
   parameter int unsigned CLK_DIV_ALT  = PAL_CLK_DIV,
   parameter int unsigned PHI2_LEN_ALT = PAL_PHI2_LEN,
   parameter int unsigned DW           = $clog2(max_u(CLK_DIV, CLK_DIV_ALT))
) (
   input  logic clk,
   input  logic n_res,
   input  logic pal,
   input  logic adv,
   output logic p1,
   output logic wrap,
   output logic first
);

   localparam logic [DW-1:0] LAST_N   = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] LAST_A   = DW'(CLK_DIV_ALT - 1);
   localparam logic [DW-1:0] P1_END_N = DW'(CLK_DIV - PHI2_LEN);
   localparam logic [DW-1:0] P1_END_A = DW'(CLK_DIV_ALT - PHI2_LEN_ALT);

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic          pal_q, pal_d;

   // Divider and PHI2 length follow the latched mode, so they only change at a wrap.
   assign wrap  = div_cnt_q == (pal_q ? LAST_A : LAST_N);
   assign p1    = div_cnt_q < (pal_q ? P1_END_A : P1_END_N);
   assign first = div_cnt_q == '0;

   always_comb begin
      div_cnt_d = div_cnt_q;
      pal_d     = pal_q;
      if (adv) begin
         if (wrap) begin
            div_cnt_d = '0;
            pal_d     = pal;
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!n_res) begin
         div_cnt_q <= '0;
         pal_q     <= pal;
      end else begin
         div_cnt_q <= div_cnt_d;
         pal_q     <= pal_d;
      end
   end

endmodule

// File: rtl/aclk_phase_gen.sv
// CPU (PHI1/PHI2) and APU (ACLK1/nACLK2) phase generator with registered outputs.
// Optional freeze input enabled by defining ACLK_PHASE_GEN_HALT_EN.
module aclk_phase_gen
   import aclk_pkg::*;
#(
   parameter int unsigned CLK_DIV      = NTSC_CLK_DIV,
   parameter int unsigned PHI2_LEN     = NTSC_PHI2_LEN,
   parameter int unsigned CLK_DIV_ALT  = PAL_CLK_DIV,
   parameter int unsigned PHI2_LEN_ALT = PAL_PHI2_LEN,
   parameter int unsigned ACLK_DIV     = APU_ACLK_DIV
) (
   input  logic             CLK,
   input  logic             nRES,
   aclk_phase_gen_if.master bus
);

   localparam int unsigned   CW       = $clog2(ACLK_DIV);
   localparam logic [CW-1:0] CYC_LAST = CW'(ACLK_DIV - 1);
   localparam logic [CW-1:0] CYC_HALF = CW'(ACLK_DIV / 2);

   logic          adv;
   logic          p1;
   logic          wrap;
   logic          first;
   logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
   phase_t        phase_q, phase_d;
   logic          cyc_start_q, cyc_start_d;
   logic          aclk_start_q, aclk_start_d;

`ifdef ACLK_PHASE_GEN_HALT_EN
   assign adv = ~bus.HALT;
`else
   assign adv = 1'b1;
`endif

   cpu_cycle_divider #(
      .CLK_DIV      (CLK_DIV),
      .PHI2_LEN     (PHI2_LEN),
      .CLK_DIV_ALT  (CLK_DIV_ALT),
      .PHI2_LEN_ALT (PHI2_LEN_ALT)
   ) u_div (
      .clk   (CLK),
      .n_res (nRES),
      .pal   (bus.PAL),
      .adv   (adv),
      .p1    (p1),
      .wrap  (wrap),
      .first (first)
   );

   // While halted every register holds, except the strobes which drop to 0
   // so a frozen first clock is not reported twice.
   always_comb begin
      cyc_cnt_d    = cyc_cnt_q;
      phase_d      = phase_q;
      cyc_start_d  = 1'b0;
      aclk_start_d = 1'b0;
      if (adv) begin
         if (bus.RES) begin
            cyc_cnt_d = '0;
         end else if (wrap) begin
            cyc_cnt_d = (cyc_cnt_q == CYC_LAST) ? '0 : cyc_cnt_q + 1'b1;
         end
         phase_d.phi1    = p1;
         phase_d.phi2    = ~p1;
         phase_d.aclk1   = p1 & (cyc_cnt_q == '0) & ~bus.RES;
         phase_d.n_aclk2 = ~(p1 & (cyc_cnt_q == CYC_HALF) & ~bus.RES);
         cyc_start_d     = first;
         aclk_start_d    = first & (cyc_cnt_q == '0) & ~bus.RES;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRES) begin
         cyc_cnt_q    <= '0;
         phase_q      <= '{phi1: 1'b1, phi2: 1'b0, aclk1: 1'b0, n_aclk2: 1'b1};
         cyc_start_q  <= 1'b0;
         aclk_start_q <= 1'b0;
      end else begin
         cyc_cnt_q    <= cyc_cnt_d;
         phase_q      <= phase_d;
         cyc_start_q  <= cyc_start_d;
         aclk_start_q <= aclk_start_d;
      end
   end

   assign bus.PHI1       = phase_q.phi1;
   assign bus.PHI2       = phase_q.phi2;
   assign bus.ACLK1      = phase_q.aclk1;
   assign bus.nACLK2     = phase_q.n_aclk2;
   assign bus.CYC_START  = cyc_start_q;
   assign bus.ACLK_START = aclk_start_q;

endmodule
